// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program image loader.
// Header is a 16-bit big-endian word count; payload words are big-endian.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int WORD_BYTES   = 4;
  localparam int HEADER_BYTES = 2;

  // A header is usable only if it asks for at least one word and no more than the memory holds.
  function automatic logic count_legal(input logic [15:0] cnt, input int unsigned max_words);
    return (cnt != 16'd0) && (32'(cnt) <= max_words);
  endfunction

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// Collects stream bytes MSB-first into a word.
// word_full flags the cycle whose accepted byte completes the word.
module program_loader_byte_word_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic        word_full,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]              idx;
  logic [8*(WORD_BYTES-1)-1:0]   shreg;

  // The incoming byte lands in the low lane combinationally so the full word is
  // available on the same edge that accepts its last byte.
  assign word      = {shreg, byte_data};
  assign word_full = shift_en && (idx == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= word[8*(WORD_BYTES-1)-1:0];
      idx   <= word_full ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the
// processor in reset until every word has been written.
//
// state  | meaning
// IDLE   | waiting for start, cpu held
// HDR_HI | taking count[15:8]
// HDR_LO | taking count[7:0], validating count
// DATA   | collecting the 4 bytes of a word
// WRITE  | one-cycle memory write strobe
// DONE   | load complete, cpu released
// ERROR  | header rejected, cpu held
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  state_t                          state;
  logic [8*(HEADER_BYTES-1)-1:0]   count_hi;
  logic [15:0]                     count;
  logic [15:0]                     words_left;
  logic                            accept;
  logic                            packer_clear;
  logic                            packer_shift;
  logic                            word_full;
  logic [31:0]                     word;

  assign accept       = byte_valid && byte_ready;
  assign count        = {count_hi, byte_data};
  assign packer_clear = (state == HDR_LO) && accept;
  assign packer_shift = (state == DATA) && accept;

  program_loader_byte_word_packer u_byte_word_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (packer_clear),
    .shift_en  (packer_shift),
    .byte_data (byte_data),
    .word_full (word_full),
    .word      (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      count_hi   <= '0;
      words_left <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= HDR_HI;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_addr   <= BASE_ADDR;
          end
        end

        HDR_HI: begin
          if (accept) begin
            count_hi <= byte_data;
            state    <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (accept) begin
            if (count_legal(count, MAX_WORDS)) begin
              words_left <= count;
              state      <= DATA;
            end else begin
              byte_ready <= 1'b0;
              error      <= 1'b1;
              state      <= ERROR;
            end
          end
        end

        DATA: begin
          if (accept && word_full) begin
            byte_ready <= 1'b0;
            mem_write  <= 1'b1;
            mem_wdata  <= word;
            state      <= WRITE;
          end
        end

        WRITE: begin
          mem_write  <= 1'b0;
          mem_addr   <= mem_addr + 32'd4;
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) begin
            cpu_hold <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= DATA;
          end
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          mem_write  <= 1'b0;
        end
      endcase
    end
  end

endmodule
